hcode_ap_fifo_buf: RTL
======================

// Module: hcode_ap_fifo_buf
// PURPOSE
//  Synchronous 128-bit first-word-fall-through FIFO presenting both ap_fifo port sets of a subshell IP:
//  - a write side matching the IP output (din/full/write);
//  - a read side matching the IP input (dout/empty_n/read).
//  Instanced per channel between the shell stream and a subshell.
//  Buffers traffic, reports occupancy, and latches protocol violations.
// PARAMETERS
//  DATA_W       128  payload width in bits
//  DEPTH        512  capacity in words; power of 2, >= 4
//  AFULL_THRESH 448  wr_almost_full asserts when count >= this; 1..DEPTH
// PORTS
//  ap_clk          in   1            single clock for all logic
//  ap_rst          in   1            synchronous reset, active-high
//  wr_din          in   DATA_W       write data
//  wr_write        in   1            write strobe
//  wr_full         out  1            1 = no space; write ignored
//  wr_almost_full  out  1            count >= AFULL_THRESH
//  rd_dout         out  DATA_W       head word; valid while rd_empty_n=1
//  rd_empty_n      out  1            1 = rd_dout holds valid head word
//  rd_read         in   1            pop strobe
//  count           out  clog2(DEPTH+1)  words held, including the output register
//  overflow        out  1            sticky: write attempted while wr_full
//  underflow       out  1            sticky: read attempted while !rd_empty_n
// BEHAVIOUR
//  - Reset (ap_rst=1 at edge): pointers, count, out_valid, overflow and underflow go to 0;
//    rd_dout=0, rd_empty_n=0, wr_full=0, wr_almost_full=0.
//    Reset mid-traffic discards all contents; no strobe in the reset cycle has effect.
//  - Storage: DEPTH-entry simple dual-port RAM (1-cycle registered read) plus output word register.
//    - ram_cnt counts RAM words. count = ram_cnt + out_valid, never exceeding DEPTH.
//  - All status outputs are registered and decoded from state at the clock edge:
//    - wr_full  = (count == DEPTH)
//    - rd_empty_n = out_valid
//  - Write accepted iff wr_write & !wr_full. On accept: RAM[wr_ptr] <= wr_din; wr_ptr++ (mod DEPTH).
//  - Pop accepted iff rd_read & rd_empty_n.
//  - Prefetch: ren = (ram_cnt != 0) & (!out_valid | pop).
//    - On ren: rd_dout <= RAM[rd_ptr]; rd_ptr++; out_valid <= 1.
//    - else on pop: out_valid <= 0; rd_dout holds its last value.
//  - Latency: a word written into an empty FIFO at edge k gives rd_empty_n=1 after edge k+1 (2 edges).
//  - Throughput: 1 word/cycle sustained in both directions.
//  - Simultaneous write+pop: both take effect; count unchanged.
//  - At full: the write is rejected even if a pop occurs in the same cycle. overflow <= 1; count drops by 1.
//  - At empty: the write is accepted; the read is ignored; underflow <= 1.
//  - Write rejected at full: no pointer or data change. Read while empty: rd_dout unchanged.
//  - Pointer wrap: ptr width clog2(DEPTH); natural modulo wrap; fullness from count, not pointer compare.
//  - overflow and underflow clear only on ap_rst.
//  - Never ren when ram_cnt==0, so no read-during-write hazard on one address.
// STRUCTURE
//  - Shared package hcode_shell_pkg:
//    - localparam HCODE_DATA_W = 128;
//    - clog2 function for count and pointer widths.
//  - One sub-module: hcode_sdp_ram (DATA_W x DEPTH, write port A, registered read port B with enable),
//    inferred as BRAM.
//  - Top holds the pointers, ram_cnt, out_valid, status registers and sticky flags.
// TESTING (DEPTH=8, AFULL_THRESH=6 for the bench)
//  1. Reset, then write 0x1 at edge k:
//     - rd_empty_n=0 after edge k, =1 after edge k+1, rd_dout=0x1, count=1.
//  2. Write 8 words 0x10..0x17 back-to-back, no reads:
//     - wr_almost_full after the 6th write; wr_full after the 8th.
//     - A 9th write sets overflow=1 and the word is lost.
//     - Drain returns 0x10..0x17 in order.
//  3. Continuous write+read every cycle for 40 words (pointers wrap 5x):
//     - output equals input sequence, one word per cycle after 2-cycle fill.
//     - count stays <= 2; no flags.
//  4. At full, assert wr_write+rd_read together:
//     - head word popped, write rejected, count 8->7, overflow=1.
//  5. At empty, assert wr_write+rd_read with 0xAA:
//     - write accepted, underflow=1, later rd_dout=0xAA.
//  6. Fill 5 words, pulse ap_rst mid-stream with strobes high:
//     - count=0, rd_empty_n=0, flags 0 next cycle.
//     - Later writes read back correctly.

Source files
------------

// File: rtl/hcode_shell_pkg.sv
// Shared definitions for the hcode shell-side buffering blocks.
// Holds the default payload width and a constant-foldable clog2.
package hcode_shell_pkg;

    localparam int HCODE_DATA_W = 128;

    // Bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hcode_sdp_ram.sv
// Simple dual-port RAM: write port A, registered read port B with enable.
// Only the read register is reset; the array itself is left to infer as block RAM.
module hcode_sdp_ram
    import hcode_shell_pkg::*;
#(
    parameter int DATA_W = HCODE_DATA_W,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hcode_ap_fifo_buf.sv
// First-word-fall-through FIFO bridging the ap_fifo write side (din/full/write)
// and read side (dout/empty_n/read), with occupancy and sticky protocol-error flags.
module hcode_ap_fifo_buf
    import hcode_shell_pkg::*;
#(
    parameter int DATA_W       = HCODE_DATA_W,
    parameter int DEPTH        = 512,
    parameter int AFULL_THRESH = 448
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [DATA_W-1:0]          wr_din,
    input  logic                       wr_write,
    output logic                       wr_full,
    output logic                       wr_almost_full,
    output logic [DATA_W-1:0]          rd_dout,
    output logic                       rd_empty_n,
    input  logic                       rd_read,
    output logic [clog2(DEPTH+1)-1:0]  count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ram_cnt;
    logic [CNT_W-1:0] ram_cnt_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             out_valid;
    logic             out_valid_nxt;
    logic             wr_acc;
    logic             pop;
    logic             ren;

    // Strobes are masked during reset so nothing moves in the reset cycle.
    // The RAM is only read when it holds a word, which rules out a same-address
    // read-during-write: a freshly written word becomes readable one cycle later.
    always_comb begin
        wr_acc        = wr_write & ~wr_full & ~ap_rst;
        pop           = rd_read & out_valid & ~ap_rst;
        ren           = (ram_cnt != '0) & (~out_valid | pop) & ~ap_rst;
        ram_cnt_nxt   = ram_cnt + CNT_W'(wr_acc) - CNT_W'(ren);
        out_valid_nxt = ren | (out_valid & ~pop);
        count_nxt     = ram_cnt_nxt + CNT_W'(out_valid_nxt);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_cnt        <= '0;
            out_valid      <= 1'b0;
            count          <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ren) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ram_cnt        <= ram_cnt_nxt;
            out_valid      <= out_valid_nxt;
            count          <= count_nxt;
            wr_full        <= (count_nxt == CNT_W'(DEPTH));
            wr_almost_full <= (count_nxt >= CNT_W'(AFULL_THRESH));
            overflow       <= overflow | (wr_write & wr_full);
            underflow      <= underflow | (rd_read & ~out_valid);
        end
    end

    assign rd_empty_n = out_valid;

    // The RAM read register doubles as the output word register.
    hcode_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_din),
        .re    (ren),
        .raddr (rd_ptr),
        .rdata (rd_dout)
    );

endmodule
